// File: rtl/serial_word_queue_if.sv
// Signal bundle between a serial word producer/consumer and serial_word_queue.
// The queue side uses the slave modport; the environment driving strobes uses master.
interface serial_word_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Strobe semantics: write_in and dequeue_in are level inputs; the queue acts once on
   // each 0->1 transition it samples, so holding a strobe high never repeats the action.
   logic          data_in;
   logic          write_in;
   logic          dequeue_in;
   logic          data_out;
   logic          data_valid;
   logic          status_out;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic          fsm_state;

   modport master (
      output data_in, write_in, dequeue_in,
      input  data_out, data_valid, status_out, full, count, overflow, fsm_state
   );

   modport slave (
      input  data_in, write_in, dequeue_in,
      output data_out, data_valid, status_out, full, count, overflow, fsm_state
   );
endinterface

// File: rtl/serial_word_queue.sv
// Serial-in/serial-out word queue: MSB-first deserializer, DEPTH-entry FIFO, timed serializer.
// Optional trailing even-parity bit on replay when SERIAL_WORD_QUEUE_PARITY_EN is defined.
module serial_word_queue #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int BIT_CYCLES = 10
) (
   input  logic                clock1M,
   input  logic                reset,
   serial_word_queue_if.slave  bus
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int BCW = $clog2(WIDTH + 1);
   localparam int CCW = $clog2(BIT_CYCLES + 1);
`ifdef SERIAL_WORD_QUEUE_PARITY_EN
   localparam int SW  = WIDTH + 1;
`else
   localparam int SW  = WIDTH;
`endif
   localparam int SIW = $clog2(SW + 1);

   localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
   localparam logic [CCW-1:0] CYC_LAST  = CCW'(BIT_CYCLES - 1);
   localparam logic [SIW-1:0] SLOT_LAST = SIW'(SW - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   ser_state_t state, next_state;

   logic             write_q, deq_q;
   logic             write_rise, deq_rise;
   logic [WIDTH-2:0] asm_reg;
   logic [BCW-1:0]   bit_cnt;
   logic [WIDTH-1:0] next_word;
   logic             word_done;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count_r;
   logic             full_c, not_empty;
   logic             push, pop;
   logic             overflow_r;
   logic [WIDTH-1:0] head;
   logic [SW-1:0]    load_word;

   logic [SW-1:0]    shift_reg;
   logic [CCW-1:0]   cyc_cnt;
   logic [SIW-1:0]   slot;
   logic             last_cycle;
   logic             data_out_c, data_valid_c;

   // ---------------- strobe edge detection ----------------
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         write_q <= 1'b0;
         deq_q   <= 1'b0;
      end else begin
         write_q <= bus.write_in;
         deq_q   <= bus.dequeue_in;
      end
   end

   assign write_rise = bus.write_in & ~write_q;
   assign deq_rise   = bus.dequeue_in & ~deq_q;

   // ---------------- deserializer ----------------
   // Only WIDTH-1 bits are stored; the final bit completes the word straight from data_in.
   assign next_word = {asm_reg, bus.data_in};
   assign word_done = write_rise && (bit_cnt == BIT_LAST);

   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         asm_reg <= '0;
         bit_cnt <= '0;
      end else if (write_rise) begin
         asm_reg <= next_word[WIDTH-2:0];
         bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
   end

   // ---------------- FIFO ----------------
   // Full is judged on the pre-update count, so a same-cycle pop cannot make room for a push.
   assign full_c    = (count_r == DEPTH_C);
   assign not_empty = (count_r != '0);
   assign push      = word_done && !full_c;
   assign pop       = (state == IDLE) && deq_rise && not_empty;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clock1M) begin
      if (push) begin
         mem[wr_ptr] <= next_word;
      end
   end

   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
         if (word_done && full_c) begin
            overflow_r <= 1'b1;
         end
      end
   end

`ifdef SERIAL_WORD_QUEUE_PARITY_EN
   assign load_word = {head, ^head};
`else
   assign load_word = head;
`endif

   // ---------------- serializer datapath ----------------
   assign last_cycle = (state == SHIFT) && (cyc_cnt == CYC_LAST) && (slot == SLOT_LAST);

   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         cyc_cnt   <= '0;
         slot      <= '0;
      end else if (pop) begin
         shift_reg <= load_word;
         cyc_cnt   <= '0;
         slot      <= '0;
      end else if (state == SHIFT) begin
         if (cyc_cnt == CYC_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {shift_reg[SW-2:0], 1'b0};
            slot      <= slot + 1'b1;
         end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
      end
   end

   // ---------------- serializer FSM ----------------
   always_ff @(posedge clock1M or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (pop) next_state = SHIFT;
         SHIFT:   if (last_cycle) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      data_out_c   = 1'b0;
      data_valid_c = 1'b0;
      if (state == SHIFT) begin
         data_valid_c = 1'b1;
         data_out_c   = shift_reg[SW-1];
      end
   end

   assign bus.data_out   = data_out_c;
   assign bus.data_valid = data_valid_c;
   assign bus.status_out = not_empty;
   assign bus.full       = full_c;
   assign bus.count      = count_r;
   assign bus.overflow   = overflow_r;
   assign bus.fsm_state  = state;

endmodule

// File: doc/serial_word_queue.md
# serial_word_queue

Parametrised serial-in / serial-out word queue, the successor of the 8-bit single-channel byte queue at the design top. It collects strobed serial bits MSB-first into WIDTH-bit words and buffers them in a DEPTH-entry circular FIFO. On request it replays one word MSB-first on a serial output, holding each bit for a programmable number of cycles. Adds occupancy/full/overflow reporting and an optional parity bit.

## Interface

- WIDTH, 8: bits per word; ≥2.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- BIT_CYCLES, 10: clock cycles each output bit is held; ≥1.

- clock1M  in  1  system clock, 1 MHz nominal; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0); one clock, no other reset.
- data_in  in  1  serial input bit, sampled on write strobe edge.
- write_in  in  1  write strobe; a 0→1 transition captures data_in.
- dequeue_in  in  1  dequeue request; a 0→1 transition starts replay of the oldest word.
- data_out  out  1  serial output bit.
- data_valid  out  1  high while data_out carries a word bit.
- status_out  out  1  high when FIFO holds ≥1 word.
- full  out  1  high when FIFO holds DEPTH words.
- count  out  $clog2(DEPTH)+1  words stored.
- overflow  out  1  sticky: a completed word was dropped because FIFO was full.

## Operation

- Edge detect: write_in and dequeue_in each registered once; rise = current 1 and registered 0. Level holds produce one event.
- Deserializer: on a write rise, data_in shifts into the assembly register LSB end; bit counter increments. On the WIDTH-th bit the full word is pushed (or dropped with overflow←1 if full) and the bit counter returns to 0. No timeout: partial words persist indefinitely.
- FIFO: write/read pointers of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count tracks occupancy.
- Serializer FSM, states IDLE and SHIFT:
  - IDLE: on dequeue rise with count>0, load shift register from FIFO head, advance read pointer, enter SHIFT. Dequeue rise with count=0 is ignored (no state change, no error flag).
  - SHIFT: data_out = shift register MSB; after BIT_CYCLES cycles shift left one bit. After the last bit's BIT_CYCLES cycles, return to IDLE.
  - Dequeue rises during SHIFT are ignored, not queued.
- Simultaneous push and pop in one cycle: both performed, count unchanged. A word pushed in cycle N is not poppable in cycle N (pop decision uses count before update); with count=0 the dequeue is ignored.
- Push when full with a pop in the same cycle: still dropped (full evaluated before pop).

## Timing

- Reset values: data_out 0, data_valid 0, status_out 0, full 0, count 0, overflow 0; FSM IDLE; pointers, bit counter, edge registers 0. Reset mid-word or mid-replay discards everything immediately.
- Push: WIDTH-th write rise sampled at edge N → count/status_out/full updated after edge N.
- Replay: dequeue rise sampled at edge N → data_valid=1 and first bit (word MSB) on data_out after edge N; count decrements after edge N.
- Each bit stable for exactly BIT_CYCLES cycles; a word occupies WIDTH×BIT_CYCLES cycles (plus BIT_CYCLES with parity). data_valid falls and data_out returns to 0 after the last bit's final cycle.
- Earliest next replay: dequeue rise sampled on the first IDLE cycle.

## Configuration

- SERIAL_WORD_QUEUE_PARITY_EN defined: after the WIDTH data bits, one extra bit of even parity (XOR of the word) is sent for BIT_CYCLES cycles with data_valid high; replay lasts (WIDTH+1)×BIT_CYCLES cycles.
- Undefined: no parity bit; replay lasts WIDTH×BIT_CYCLES cycles; no parity logic synthesised.

## Test plan

- Reset: hold reset=0 for 10 cycles mid-activity → all outputs 0, count 0; after release a dequeue rise produces no data_valid.
- Default params, send 8'hA5 then 8'h3C (bit strobes 10 cycles high/10 low) → count=2, status_out=1; two dequeues output 10100101 then 00111100, each bit held 10 cycles, count returns to 0, status_out 0.
- Fill: push DEPTH+1 words (0x01..0x09) → full=1 after 8th, overflow=1 after 9th, count=8; replay all → 0x01..0x08 in order, pointer wrap correct.
- Dequeue held high 50 cycles and a second rise during SHIFT → exactly one word replayed.
- Final bit of a word strobed in the same cycle as a dequeue rise with count=1 → count stays 1, outgoing word is the older one.
- With SERIAL_WORD_QUEUE_PARITY_EN: 8'hA5 → 9 bits 101001010 (parity 0); 8'h07 → trailing parity bit 1.
